// File: rtl/dmem_axi_bridge.sv
// Data-cache memory-side responder: turns one m_* word request into a single-beat AXI4 read or write.
// Optional build macro POSTED_WRITE_EN: writes complete to the cache after AW/W; the B response is drained in the background.
module dmem_axi_bridge #(
    parameter int         A_WIDTH = 32,
    parameter logic [3:0] AXI_ID  = 4'd1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] s_a,
    input  logic [31:0]        s_din,
    output logic [31:0]        s_dout,
    input  logic               s_strobe,
    input  logic               s_rw,
    output logic               s_ready,
    output logic               s_err,
    output logic [3:0]         arid,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [3:0]         awid,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        s_dout_q, s_dout_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic               s_ready_q, s_ready_d;
    logic               s_err_q, s_err_d;
    logic               req_ok_s;
    logic               rlast_unused_s;
`ifdef POSTED_WRITE_EN
    logic               b_pending_q, b_pending_d;
`endif

    // Single-beat, full-word transfers only; rlast carries no information here.
    assign rlast_unused_s = rlast;
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arsize  = 3'b010;
    assign awsize  = 3'b010;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wstrb   = 4'hF;
    assign wlast   = 1'b1;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign s_ready = s_ready_q;
    assign s_err   = s_err_q;
    assign s_dout  = s_dout_q;

    // Next-state and next-output logic; every AXI/cache output is registered from these.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        s_dout_d  = s_dout_q;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = 1'b0;
        s_ready_d = 1'b0;
        s_err_d   = 1'b0;
`ifdef POSTED_WRITE_EN
        // The cache stalls until the previous write's B response has been drained.
        b_pending_d = b_pending_q;
        if (b_pending_q && bvalid && bready_q) begin
            b_pending_d = 1'b0;
        end else begin
            b_pending_d = b_pending_q;
        end
        req_ok_s = ~b_pending_q;
`else
        req_ok_s = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (s_strobe && req_ok_s) begin
                    addr_d  = {s_a[A_WIDTH-1:2], 2'b00};
                    wdata_d = s_din;
                    if (s_rw) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d  = RD_DATA;
                    rready_d = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_q) begin
                    s_dout_d  = rdata;
                    s_err_d   = (rresp != 2'b00);
                    s_ready_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave only when both have handshaken.
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (!awvalid_d && !wvalid_d) begin
`ifdef POSTED_WRITE_EN
                    state_d     = DONE;
                    s_ready_d   = 1'b1;
                    b_pending_d = 1'b1;
`else
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
`endif
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (bvalid && bready_q) begin
                    s_err_d   = (bresp != 2'b00);
                    s_ready_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
`ifdef POSTED_WRITE_EN
        bready_d = b_pending_d;
`endif
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            addr_q    <= {A_WIDTH{1'b0}};
            wdata_q   <= 32'd0;
            s_dout_q  <= 32'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            s_ready_q <= 1'b0;
            s_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            s_dout_q  <= s_dout_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            s_ready_q <= s_ready_d;
            s_err_q   <= s_err_d;
        end
    end

`ifdef POSTED_WRITE_EN
    // Outstanding B response tracker.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            b_pending_q <= 1'b0;
        end else begin
            b_pending_q <= b_pending_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed self-checking bench for dmem_axi_bridge with a small configurable-latency AXI slave.
module tb_dmem_axi_bridge;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] s_a, s_din, s_dout;
    logic        s_strobe, s_rw, s_ready, s_err;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, b_pend, aw_got, w_got;
    int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_rdy = 0;

    always #5 clk = ~clk;

    dmem_axi_bridge #(.A_WIDTH(32), .AXI_ID(4'd1)) dut (
        .clk(clk), .clrn(clrn),
        .s_a(s_a), .s_din(s_din), .s_dout(s_dout), .s_strobe(s_strobe), .s_rw(s_rw),
        .s_ready(s_ready), .s_err(s_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    assign arready = arvalid && (ar_cnt >= ar_delay);
    assign rvalid  = r_pend && (r_cnt >= r_delay);
    assign rdata   = rdata_cfg;
    assign rresp   = rvalid ? rresp_cfg : 2'b00;
    assign rlast   = rvalid;
    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign bvalid  = b_pend && (b_cnt >= b_delay);
    assign bresp   = bvalid ? bresp_cfg : 2'b00;

    // Slave model: wait counters per channel plus handshake tallies.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (arvalid && arready) begin
                r_pend <= 1'b1; r_cnt <= 0; n_ar <= n_ar + 1;
            end else if (rvalid && rready) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_cnt <= r_cnt + 1;
            end
            if (awvalid && awready) n_aw <= n_aw + 1;
            if (wvalid && wready) n_w <= n_w + 1;
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (awvalid && awready) aw_got <= 1'b1;
                if (wvalid && wready) w_got <= 1'b1;
                if (bvalid && bready) b_pend <= 1'b0;
                else if (b_pend) b_cnt <= b_cnt + 1;
            end
            if (bvalid && bready) n_b <= n_b + 1;
            if (s_ready) n_rdy <= n_rdy + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the number of extra cycles until s_ready is seen (0 if already high).
    task automatic wait_ready(input string tag, input int max, output int lat);
        lat = 0;
        while (!s_ready && lat < max) begin
            tick();
            lat++;
        end
        check_val({tag, "_ready_seen"}, s_ready, 1'b1);
    endtask

    task automatic request(input logic rw, input logic [31:0] a, input logic [31:0] d);
        s_strobe = 1'b1; s_rw = rw; s_a = a; s_din = d;
    endtask

    initial begin
        int lat, nar, naw, nw, nr, nb;
        logic early_ar;
        clrn = 1'b0; s_a = 32'h0; s_din = 32'h0; s_strobe = 1'b0; s_rw = 1'b0;
        tick(); tick();
        clrn = 1'b1;
        tick();
        check_val("rst_arvalid", arvalid, 1'b0);
        check_val("rst_awvalid", awvalid, 1'b0);
        check_val("rst_wvalid", wvalid, 1'b0);
        check_val("rst_rready", rready, 1'b0);
        check_val("rst_bready", bready, 1'b0);
        check_val("rst_s_ready", s_ready, 1'b0);
        check_val("rst_s_err", s_err, 1'b0);
        check_val("rst_s_dout", s_dout, 32'h0);

        // Zero-wait read.
        rdata_cfg = 32'hDEADBEEF;
        request(1'b0, 32'h0000_1007, 32'h0);
        tick();
        s_strobe = 1'b0;
        check_val("rd_arvalid", arvalid, 1'b1);
        check_val("rd_araddr", araddr, 32'h0000_1004);
        check_val("rd_arlen", arlen, 8'd0);
        check_val("rd_arsize", arsize, 3'd2);
        check_val("rd_arburst", arburst, 2'b01);
        check_val("rd_arid", arid, 4'd1);
        wait_ready("rd", 10, lat);
        check_val("rd_latency", lat + 1, 3);
        check_val("rd_dout", s_dout, 32'hDEADBEEF);
        check_val("rd_err", s_err, 1'b0);
        tick();
        check_val("rd_pulse_one", s_ready, 1'b0);

        // Write with AW delayed 2 cycles, W immediate.
        aw_delay = 2;
        request(1'b1, 32'h2000_0010, 32'h1234_5678);
        tick();
        s_strobe = 1'b0;
        check_val("wr_awvalid0", awvalid, 1'b1);
        check_val("wr_wvalid0", wvalid, 1'b1);
        check_val("wr_awaddr", awaddr, 32'h2000_0010);
        check_val("wr_wdata", wdata, 32'h1234_5678);
        check_val("wr_wstrb", wstrb, 4'hF);
        check_val("wr_wlast", wlast, 1'b1);
        check_val("wr_awlen", awlen, 8'd0);
        tick();
        check_val("wr_wvalid1", wvalid, 1'b0);
        check_val("wr_awvalid1", awvalid, 1'b1);
        tick();
        check_val("wr_awvalid2", awvalid, 1'b1);
        tick();
        check_val("wr_awvalid3", awvalid, 1'b0);
        wait_ready("wr", 10, lat);
`ifdef POSTED_WRITE_EN
        check_val("wr_latency", lat + 4, 4);
`else
        check_val("wr_latency", lat + 4, 5);
        check_val("wr_b_before_ready", n_b, 1);
`endif
        check_val("wr_dout_kept", s_dout, 32'hDEADBEEF);
        aw_delay = 0;
        tick();

        // Error responses.
        rresp_cfg = 2'b10; rdata_cfg = 32'hCAFEF00D;
        request(1'b0, 32'h0000_0100, 32'h0);
        tick();
        s_strobe = 1'b0;
        wait_ready("rderr", 10, lat);
        check_val("rderr_err", s_err, 1'b1);
        check_val("rderr_dout", s_dout, 32'hCAFEF00D);
        tick();
        check_val("rderr_err_drop", s_err, 1'b0);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        request(1'b1, 32'h0000_0200, 32'hA5A5A5A5);
        tick();
        s_strobe = 1'b0;
        wait_ready("wrerr", 10, lat);
`ifdef POSTED_WRITE_EN
        check_val("wrerr_err", s_err, 1'b0);
`else
        check_val("wrerr_err", s_err, 1'b1);
`endif
        check_val("wrerr_dout", s_dout, 32'hCAFEF00D);
        bresp_cfg = 2'b00;
        tick(); tick(); tick();

        // Back-to-back with strobe held high: read then write.
        rdata_cfg = 32'h1111_2222;
        nar = n_ar; naw = n_aw; nw = n_w; nr = n_rdy;
        request(1'b0, 32'h0000_0040, 32'h0);
        wait_ready("b2b_rd", 20, lat);
        s_rw = 1'b1; s_din = 32'h5566_7788;
        tick();
        check_val("b2b_idle_ready", s_ready, 1'b0);
        check_val("b2b_idle_arvalid", arvalid, 1'b0);
        check_val("b2b_idle_awvalid", awvalid, 1'b0);
        tick();
        check_val("b2b_awvalid", awvalid, 1'b1);
        wait_ready("b2b_wr", 20, lat);
        s_strobe = 1'b0;
        tick(); tick();
        check_val("b2b_n_ar", n_ar, nar + 1);
        check_val("b2b_n_aw", n_aw, naw + 1);
        check_val("b2b_n_w", n_w, nw + 1);
        check_val("b2b_n_ready", n_rdy, nr + 2);
        check_val("b2b_dout", s_dout, 32'h1111_2222);
        tick(); tick();

        // Reset in the middle of a read address phase.
        ar_delay = 5;
        nr = n_rdy;
        request(1'b0, 32'h0000_3000, 32'h0);
        tick();
        s_strobe = 1'b0;
        check_val("rst_mid_arvalid_pre", arvalid, 1'b1);
        #2 clrn = 1'b0;
        #1;
        check_val("rst_mid_arvalid", arvalid, 1'b0);
        check_val("rst_mid_dout", s_dout, 32'h0);
        tick(); tick();
        #2 clrn = 1'b1;
        ar_delay = 0;
        tick(); tick(); tick();
        check_val("rst_mid_no_ready", n_rdy, nr);
        check_val("rst_mid_idle_arvalid", arvalid, 1'b0);
        rdata_cfg = 32'h0BAD_CAFE;
        request(1'b0, 32'h0000_3000, 32'h0);
        tick();
        s_strobe = 1'b0;
        wait_ready("rst_after", 10, lat);
        check_val("rst_after_latency", lat + 1, 3);
        check_val("rst_after_dout", s_dout, 32'h0BAD_CAFE);
        tick(); tick();

`ifdef POSTED_WRITE_EN
        // Posted write followed by a read while B is outstanding.
        b_delay = 5;
        nb = n_b;
        request(1'b1, 32'h0000_0500, 32'hFEED_0001);
        tick();
        s_strobe = 1'b0;
        wait_ready("pw", 10, lat);
        check_val("pw_b_not_yet", n_b, nb);
        check_val("pw_bvalid_low", bvalid, 1'b0);
        check_val("pw_bready", bready, 1'b1);
        request(1'b0, 32'h0000_0600, 32'h0);
        early_ar = 1'b0;
        lat = 0;
        while (!arvalid && lat < 30) begin
            tick();
            lat++;
            if (arvalid && n_b == nb) early_ar = 1'b1;
        end
        s_strobe = 1'b0;
        check_val("pw_ar_seen", arvalid, 1'b1);
        check_val("pw_ar_after_b", early_ar, 1'b0);
        check_val("pw_b_done", n_b, nb + 1);
        wait_ready("pw_rd", 10, lat);
        b_delay = 0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_axi_bridge.md
Name: dmem_axi_bridge

Overview:
- Memory-side responder for the write-through data cache's m_* request interface (strobe/rw/ready, single 32-bit word).
- Accepts one word request at a time and converts it into a single-beat AXI4 read or write transaction.
- Returns read data and a one-cycle ready pulse to the cache.
- Sits between the data cache and the SoC AXI crossbar.

Parameters:
- A_WIDTH, 32: request and AXI address width.
- AXI_ID, 4'd1: value driven on arid/awid (4 bits).

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- s_a  in  A_WIDTH  request word address (byte address, bits [1:0] ignored, forced to 0 on AXI)
- s_din  in  32  write data from cache
- s_dout  out  32  read data to cache
- s_strobe  in  1  request valid
- s_rw  in  1  0 read, 1 write
- s_ready  out  1  one-cycle completion pulse
- s_err  out  1  pulses with s_ready when xRESP != OKAY
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/A_WIDTH/8/3/2/1  AXI read address channel
- arready  in  1
- rdata/rresp/rlast/rvalid  in  32/2/1/1; rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/A_WIDTH/8/3/2/1
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1
- wready  in  1
- bresp/bvalid  in  2/1; bready  out  1

Behaviour:
- Constants: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wstrb=4'hF, wlast=1.
- Reset values: all valids/readies 0, s_ready=0, s_err=0, s_dout=0, state IDLE.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - Samples s_strobe; on 1, latch s_a (low 2 bits cleared), s_din, s_rw.
  - Go to RD_ADDR (rw=0) or WR_REQ (rw=1).
  - s_strobe=0 keeps IDLE.
- RD_ADDR:
  - arvalid=1 with latched address, held stable until arready.
  - On arvalid&arready go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, register rdata into s_dout and err=(rresp!=0), then go to DONE.
  - rlast ignored (single beat).
- WR_REQ:
  - awvalid and wvalid both raised on entry.
  - Each deasserts independently after its own handshake, whether both occur in the same cycle or in different cycles.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, err=(bresp!=0), go to DONE.
- DONE:
  - s_ready=1 and s_err=err for exactly one cycle, then IDLE.
  - s_dout holds its value until the next read completes; writes do not alter it.
- Latency: zero-wait slave (arready=1, rvalid the next cycle) gives s_ready 3 cycles after the strobe-sample cycle. Writes behave the same with awready=wready=1 and bvalid the next cycle.
- Back-to-back requests:
  - The cache may hold s_strobe high through the s_ready cycle.
  - Because DONE ignores strobe, a new request is sampled in the following IDLE cycle.
  - No request is ever accepted twice within one DONE pulse.
- Request-side inputs are ignored outside IDLE. Changes to s_a/s_din mid-transaction have no effect.
- Reset mid-transaction: immediate return to IDLE, all AXI valids/readies drop, pending transaction abandoned (system-wide reset).
- Spurious rvalid/bvalid outside the expected state are not acknowledged (ready=0).

Optional Feature:
- Macro POSTED_WRITE_EN.
- Defined:
  - Writes complete toward the cache once both AW and W handshakes finish. WR_REQ goes to DONE directly, s_err=0.
  - Internal b_pending flag is set. bready=1 whenever b_pending; bvalid clears it; bresp errors are discarded.
  - In IDLE, a new request is not sampled while b_pending=1 (the cache stalls).
  - The B handshake may coincide with the DONE or IDLE cycle.
- Undefined: writes wait for B as described in Behaviour. The b_pending logic is absent.

Test Plan:
- Read, zero-wait slave returns 32'hDEADBEEF: s_strobe=1, s_rw=0, s_a=32'h0000_1007 -> araddr=32'h0000_1004 with arlen=0 and arsize=2; s_ready pulses once, 3 cycles after strobe sample; s_dout=32'hDEADBEEF; s_err=0.
- Write, slave with awready delayed 2 cycles and wready immediate: s_a=32'h2000_0010, s_din=32'h1234_5678 -> wvalid drops after 1 cycle, awvalid stays high until the 3rd cycle; wdata=32'h1234_5678; wstrb=4'hF; s_ready after bvalid.
- Error responses: slave returns rresp=2'b10 on a read, then bresp=2'b11 on a write -> s_err=1 coincident with each s_ready pulse; s_dout updated with rdata anyway.
- Back-to-back with s_strobe held high: read then write -> exactly one AR and one AW/W issued; second request accepted in the IDLE cycle after the first s_ready.
- Reset mid-read: clrn low while arvalid=1 -> arvalid=0 asynchronously; state IDLE; no s_ready pulse; next request served normally.
- POSTED_WRITE_EN, bvalid delayed 5 cycles: write then read -> write's s_ready precedes bvalid; read's arvalid not raised until the B handshake completes.
